lsu: RTL
========

# lsu

Load/store stage of the 4-stage RISC-V pipeline; it is the consumer of the execute stage's `*_exe2lsu` register outputs. Each cycle it either passes an ALU result straight to write-back, or runs one data-memory transaction over a req/ack handshake. During a transaction it asserts `stall` to freeze upstream. Load data is lane-extracted and sign/zero-extended here, and the single registered write-back port to the register file is produced here.

## Interface
Parameters:
- `WIDTH`, 32, data/address width; only 32 is supported.

Ports:
- `clk`  in  1  clock. One clock; reset is asynchronous and active-low.
- `rstn`  in  1  asynchronous active-low reset.
- `alu_result`  in  32  effective address, or ALU result for non-memory ops.
- `Rd2_exe2lsu`  in  32  store data.
- `Ld_cntr_exe2lsu`  in  3  load type: 000 none, 001 LB, 010 LH, 011 LW, 100 LBU, 101 LHU; 110/111 treated as none.
- `St_cntr_exe2lsu`  in  2  store type: 00 none, 01 SB, 10 SH, 11 SW.
- `Memtoreg_exe2lsu`  in  2  write-back source: 01 load data; any other value selects `alu_result`.
- `RegW_exe2lsu`  in  1  register write enable.
- `wr_addr_exe2lsu`  in  5  destination register.
- `stall`  out  1  upstream must hold all `*_exe2lsu` values while high.
- `dmem_req`  out  1  memory request, held until ack.
- `dmem_we`  out  1  1 = store.
- `dmem_addr`  out  32  word-aligned address `{addr[31:2],2'b00}`.
- `dmem_be`  out  4  byte enables.
- `dmem_wdata`  out  32  lane-replicated store data.
- `dmem_rdata`  in  32  read data; valid in the `dmem_ack` cycle.
- `dmem_ack`  in  1  one-cycle completion pulse.
- `wb_en`, `wb_addr`, `wb_data`  out  1/5/32  registered write-back port.
- `misalign_err`  out  1  one-cycle pulse on a misaligned access (see Configuration).

## Operation
- A memory op is `Ld_cntr` in 001..101, or `St_cntr != 00`. If both are present, the load wins and the store is ignored.
- FSM states:
  - IDLE, memory op present: latch address, `we`, `be`, `wdata` and load type into request registers; set `dmem_req=1`; go to WAIT.
  - IDLE, no memory op: register write-back directly.
  - WAIT: hold all `dmem_*` outputs stable. On `dmem_ack`: clear `dmem_req`, register write-back, return to IDLE.
- `stall = (IDLE & mem_op & ~misalign) | (WAIT & ~dmem_ack)`.
- Store lanes:
  - SB: `be = 4'b0001 << addr[1:0]`, `wdata = {4{Rd2[7:0]}}`.
  - SH: `be = 4'b0011 << {addr[1],1'b0}`, `wdata = {2{Rd2[15:0]}}`.
  - SW: `be = 4'hF`, `wdata = Rd2`.
  - Load: `be = 4'hF`.
- Load extraction: take the byte selected by `addr[1:0]`, or the half selected by `addr[1]`. LB/LH sign-extend; LBU/LHU zero-extend.
- Write-back:
  - `wb_en = RegW & (wr_addr != 0)`.
  - `wb_data` = extended load data if `Memtoreg == 01`, else `alu_result`.
  - While stalled, `wb_en = 0` (bubble).
  - Stores complete with `wb_en = 0` regardless of `RegW`.

## Timing
- Reset values: FSM = IDLE, and every output register is 0 (`dmem_*`, `wb_*`, `misalign_err`).
- Non-memory op: `wb_*` valid 1 cycle after the inputs are presented.
- Memory op with ack in cycle k after request: the op is presented at cycle 0 and `dmem_req` rises at edge 1.
  - `dmem_req` falls and `wb_*` update at the edge after the ack cycle.
  - `stall` is high from cycle 0 through the cycle before the ack; it is low in the ack cycle, so upstream advances on that same edge.
- Back-to-back memory ops: the next op is captured in IDLE the cycle after return. Minimum memory-op throughput is 1 per 2 cycles plus memory wait.
- `dmem_ack` while in IDLE is ignored.
- Reset mid-transaction: `dmem_req` drops asynchronously and no write-back occurs.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - LH/LHU/SH with `addr[0]=1`, or LW/SW with `addr[1:0]!=0`, is misaligned.
  - On a misaligned op: no request is issued, `stall` stays 0, `wb_en=0`, and `misalign_err` pulses for 1 cycle at the next edge.
- `LSU_MISALIGN_TRAP_EN` undefined:
  - `misalign_err` is tied 0.
  - Misaligned addresses are silently aligned down: the half uses `addr[1]`, the word uses lane 0.

## Structure
- `lsu_pkg` holds:
  - `LD_NONE/LB/LH/LW/LBU/LHU` and `ST_NONE/SB/SH/SW` constants;
  - the `MEMTOREG_LOAD` constant;
  - the FSM state typedef {IDLE, WAIT}.
- Sub-module `lsu_align`: combinational. Store lane and byte-enable generation, plus load extraction and extension, driven by `addr[1:0]` and the type codes.

## Test plan
- ALU op, `alu_result=0x1234`, `RegW=1`, `wr_addr=5`, no memory op -> next cycle `wb_en=1`, `wb_addr=5`, `wb_data=0x1234`; `stall` never high.
- SB at `addr=0x103`, `Rd2=0xAABBCCDD`, ack after 2 cycles -> `dmem_addr=0x100`, `be=1000`, `wdata=0xDDDDDDDD`, `we=1`; `stall` high until the ack cycle; `wb_en=0`.
- LB at `addr=0x202`, `rdata=0x00800000`, `wr_addr=7` -> `wb_data=0xFFFFFF80`. Repeat with LBU -> `0x00000080`.
- LH at `addr=0x02`, `rdata=0x8001_0000` -> `wb_data=0xFFFF8001`. Same op with `wr_addr=0` -> `wb_en=0`.
- Reset asserted while in WAIT -> `dmem_req=0` and all outputs 0 immediately. After reset release, ack is ignored and there is no write-back.
- With `LSU_MISALIGN_TRAP_EN`: LW at `addr=0x3` -> no `dmem_req`, `stall=0`, `misalign_err=1` for one cycle, `wb_en=0`.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: load/store type codes, write-back select code and FSM state type for the lsu
package lsu_pkg;
    localparam logic [2:0] LD_NONE = 3'b000;
    localparam logic [2:0] LD_LB   = 3'b001;
    localparam logic [2:0] LD_LH   = 3'b010;
    localparam logic [2:0] LD_LW   = 3'b011;
    localparam logic [2:0] LD_LBU  = 3'b100;
    localparam logic [2:0] LD_LHU  = 3'b101;
    localparam logic [1:0] ST_NONE = 2'b00;
    localparam logic [1:0] ST_SB   = 2'b01;
    localparam logic [1:0] ST_SH   = 2'b10;
    localparam logic [1:0] ST_SW   = 2'b11;
    localparam logic [1:0] MEMTOREG_LOAD = 2'b01;
    typedef enum logic {IDLE, WAIT} state_t;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: store lane/byte-enable generation and load byte/half extraction with extension
module lsu_align
    import lsu_pkg::*;
(
    input  logic        is_load,
    input  logic [1:0]  st_off,
    input  logic [1:0]  st_type,
    input  logic [31:0] st_data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    input  logic [1:0]  ld_off,
    input  logic [2:0]  ld_type,
    input  logic [31:0] rdata,
    output logic [31:0] ld_data
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // store side: loads always read the full word, stores replicate data across lanes
    always_comb begin
        be    = is_load ? 4'hF :
                st_type == ST_SB ? 4'b0001 << st_off :
                st_type == ST_SH ? 4'b0011 << {st_off[1], 1'b0} :
                st_type == ST_SW ? 4'hF : 4'h0;
        wdata = st_type == ST_SB ? {4{st_data[7:0]}} :
                st_type == ST_SH ? {2{st_data[15:0]}} : st_data;
    end

    // load side: pick the addressed byte/half, word ignores the low offset bits
    always_comb begin
        byte_v  = rdata[{ld_off, 3'b000} +: 8];
        half_v  = ld_off[1] ? rdata[31:16] : rdata[15:0];
        ld_data = ld_type == LD_LB  ? {{24{byte_v[7]}}, byte_v} :
                  ld_type == LD_LH  ? {{16{half_v[15]}}, half_v} :
                  ld_type == LD_LW  ? rdata :
                  ld_type == LD_LBU ? {24'b0, byte_v} :
                  ld_type == LD_LHU ? {16'b0, half_v} : 32'b0;
    end
endmodule

// File: rtl/lsu.sv
// lsu: load/store stage with req/ack memory FSM and registered write-back; LSU_MISALIGN_TRAP_EN enables misalignment trapping
module lsu
    import lsu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [WIDTH-1:0] Rd2_exe2lsu,
    input  logic [2:0]       Ld_cntr_exe2lsu,
    input  logic [1:0]       St_cntr_exe2lsu,
    input  logic [1:0]       Memtoreg_exe2lsu,
    input  logic             RegW_exe2lsu,
    input  logic [4:0]       wr_addr_exe2lsu,
    output logic             stall,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [WIDTH-1:0] dmem_addr,
    output logic [3:0]       dmem_be,
    output logic [WIDTH-1:0] dmem_wdata,
    input  logic [WIDTH-1:0] dmem_rdata,
    input  logic             dmem_ack,
    output logic             wb_en,
    output logic [4:0]       wb_addr,
    output logic [WIDTH-1:0] wb_data,
    output logic             misalign_err
);
    state_t           state, state_nx;
    logic             ld_op, st_op, mem_op, misalign, start, done, wb_fire;
    logic [1:0]       st_eff, off_q;
    logic [2:0]       ld_type_q;
    logic [3:0]       be_nx;
    logic [WIDTH-1:0] wdata_nx, ld_data;

    assign ld_op   = Ld_cntr_exe2lsu >= LD_LB && Ld_cntr_exe2lsu <= LD_LHU;
    assign st_op   = St_cntr_exe2lsu != ST_NONE;
    assign mem_op  = ld_op || st_op;
    assign st_eff  = ld_op ? ST_NONE : St_cntr_exe2lsu;
`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = ((Ld_cntr_exe2lsu == LD_LH || Ld_cntr_exe2lsu == LD_LHU || st_eff == ST_SH) && alu_result[0]) ||
                      ((Ld_cntr_exe2lsu == LD_LW || st_eff == ST_SW) && alu_result[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
    assign misalign_err = 1'b0;
`endif
    assign start   = state == IDLE && mem_op && !misalign;
    assign done    = state == WAIT && dmem_ack;
    assign wb_fire = (state == IDLE && !mem_op) || (done && ld_type_q != LD_NONE);
    assign stall   = start || (state == WAIT && !dmem_ack);

    lsu_align u_align (
        .is_load (ld_op),
        .st_off  (alu_result[1:0]),
        .st_type (st_eff),
        .st_data (Rd2_exe2lsu),
        .be      (be_nx),
        .wdata   (wdata_nx),
        .ld_off  (off_q),
        .ld_type (ld_type_q),
        .rdata   (dmem_rdata),
        .ld_data (ld_data)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    // next state: a legal memory op enters WAIT, the ack returns to IDLE
    always_comb begin
        state_nx = state == IDLE ? (start ? WAIT : IDLE) : (dmem_ack ? IDLE : WAIT);
    end

    // request registers held through WAIT, and the registered write-back port
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= 4'h0;
            dmem_wdata <= '0;
            ld_type_q  <= LD_NONE;
            off_q      <= 2'b00;
            wb_en      <= 1'b0;
            wb_addr    <= 5'd0;
            wb_data    <= '0;
        end else begin
            wb_en <= wb_fire && RegW_exe2lsu && wr_addr_exe2lsu != 5'd0;
            if ((state == IDLE && !mem_op) || done) begin
                wb_addr <= wr_addr_exe2lsu;
                wb_data <= Memtoreg_exe2lsu == MEMTOREG_LOAD ? ld_data : alu_result;
            end
            if (start) begin
                dmem_req   <= 1'b1;
                dmem_we    <= !ld_op;
                dmem_addr  <= {alu_result[WIDTH-1:2], 2'b00};
                dmem_be    <= be_nx;
                dmem_wdata <= wdata_nx;
                ld_type_q  <= ld_op ? Ld_cntr_exe2lsu : LD_NONE;
                off_q      <= alu_result[1:0];
            end else if (done) begin
                dmem_req   <= 1'b0;
            end
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    // one-cycle pulse when a misaligned op is dropped in IDLE
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) misalign_err <= 1'b0;
        else       misalign_err <= state == IDLE && mem_op && misalign;
    end
`endif
endmodule
